demux14_tdm: RTL and testbench
==============================

# demux14_tdm

Time-division 1-to-4 demultiplexer: the receive-side counterpart of our 4:1 selector. It takes a slot-interleaved stream `Y` (slots 0,1,2,3 = channels A,B,C,D) plus a valid/sync handshake. It tracks the slot with an internal 2-bit counter and presents each completed frame on registered parallel outputs `A`–`D` with a one-cycle `DONE` strobe. It sits after the 4:1 selector's serialized output in the course datapath and restores the four channels.

## Interface

Parameters:
- `WIDTH`, default 1: bit width of each channel/beat.

Ports:
- `CLK` in, 1 bit: single clock; all state updates on the rising edge.
- `RST` in, 1 bit: asynchronous, active-high reset.
- `Y` in, WIDTH bits: interleaved input beat.
- `VALID` in, 1 bit: `Y` carries a beat this cycle.
- `SYNC` in, 1 bit: qualified by `VALID`; the current beat is slot 0 (frame start).
- `CLR_ERR` in, 1 bit: clears the sticky `ERR`.
- `A`, `B`, `C`, `D` out, WIDTH bits each: last completed frame (slots 0..3), registered.
- `DONE` out, 1 bit: one-cycle pulse when `A`–`D` update.
- `S1`, `S0` out, 1 bit each: slot number the next beat will fill (`{S1,S0}`), registered.
- `ERR` out, 1 bit: sticky frame-alignment error.

## Operation

- State:
  - Slot counter `SEL = {S1,S0}`.
  - Shadow registers `SH0`, `SH1`, `SH2` (WIDTH each).
  - Output registers `A`–`D`, `DONE`, `ERR`.
- Reset (`RST`=1, asynchronous, regardless of `CLK`): `SEL`=0, `SH0`–`SH2`=0, `A`–`D`=0, `DONE`=0, `ERR`=0.
- Each rising edge, with `VALID`=0: no state changes except `DONE`←0 and `ERR` clear handling. `SYNC` is ignored when `VALID`=0.
- `VALID`=1 and `SYNC`=1 (forced frame start):
  - `SH0`←`Y`, `SEL`←1.
  - If `SEL`≠0 beforehand: `ERR`←1. The partial frame is discarded; `A`–`D` are unchanged and no `DONE` is issued.
- `VALID`=1, `SYNC`=0, `SEL`∈{0,1,2}: `SH[SEL]`←`Y`, `SEL`←`SEL`+1. `SEL`=0 without `SYNC` is legal (free-running framing).
- `VALID`=1, `SYNC`=0, `SEL`=3 (frame complete):
  - `A`←`SH0`, `B`←`SH1`, `C`←`SH2`, `D`←`Y`.
  - `DONE`←1.
  - `SEL` wraps to 0.
- `DONE` is 0 on every edge that does not complete a frame.
- `ERR`: set as above. `CLR_ERR`=1 clears it on the next edge. If a set condition and `CLR_ERR` occur on the same edge, set wins (`ERR`=1).
- `A`–`D` hold their value between completions and change only on a `DONE` edge, all four together.
- Not defined by design (no handshake back-pressure): the block always accepts.

## Timing

- Throughput: one beat per cycle. A frame takes 4 valid beats; back-to-back frames give `DONE` every 4th valid cycle with no bubbles.
- Latency: the slot-3 beat sampled at edge k produces `A`–`D` and `DONE`=1 visible after edge k. `DONE` drops after edge k+1 unless edge k+1 also completes a frame, which is impossible (needs 4 beats).
- `{S1,S0}` always reflects the slot for the next accepted beat, one register, no combinational path from inputs.
- Gaps: `VALID`=0 cycles inside a frame stall `SEL`. Partial shadow content is retained indefinitely.
- Reset mid-frame: the partial frame is lost, outputs are 0 immediately (asynchronously), and the next accepted beat is slot 0.

## Test plan

- **Reset**: assert `RST` mid-cycle with `A`=5 held. Required: `A`–`D`=0, `DONE`=0, `ERR`=0, `{S1,S0}`=0 immediately, before the next `CLK` edge.
- **Basic frame** (WIDTH=4): `VALID`=1 for 4 cycles with `Y`=1,2,3,4 and `SYNC` on the first. Required: after the 4th edge, `A`=1, `B`=2, `C`=3, `D`=4, and `DONE` high exactly 1 cycle. `{S1,S0}` sequence is 1,2,3,0.
- **Stalls**: the same frame with `VALID`=0 gaps of 2 cycles between beats. Required: identical `A`–`D`; `DONE` only after the 4th valid beat; `SEL` holds during gaps.
- **Back-to-back**: 8 contiguous valid beats 0xA..0xF, 0x0, 0x1, no `SYNC` after the first. Required:
  - `DONE` pulses after beats 4 and 8.
  - Second frame: `A`=0xE, `B`=0xF, `C`=0x0, `D`=0x1.
- **Misalignment**: `SYNC` with a valid beat when `{S1,S0}`=2, `Y`=7, followed by 3 more beats 8,9,10. Required:
  - `ERR`=1 and stays 1.
  - No `DONE` for the aborted frame; `A`–`D` hold the previous frame.
  - Then `A`=7, `B`=8, `C`=9, `D`=10 with `DONE`.
- **Error clear priority**: `CLR_ERR`=1 on the same edge as a new misaligned `SYNC`. Required: `ERR` stays 1. Then `CLR_ERR` alone gives `ERR`=0 after one edge.

Source files
------------

// File: rtl/demux14_tdm_if.sv
// Bus bundle for the 1-to-4 TDM demultiplexer.
// It carries the interleaved input beat with its valid/sync/clear controls,
// the recovered parallel frame, and the status outputs.
interface demux14_tdm_if #(
  parameter int WIDTH = 1
) ();
  logic [WIDTH-1:0] Y;
  logic             VALID;
  logic             SYNC;
  logic             CLR_ERR;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;
  logic [WIDTH-1:0] D;
  logic             DONE;
  logic             S1;
  logic             S0;
  logic             ERR;

  // Upstream side: produces beats and consumes the recovered frame.
  modport master (
    output Y, VALID, SYNC, CLR_ERR,
    input  A, B, C, D, DONE, S1, S0, ERR
  );

  // Demultiplexer side.
  modport slave (
    input  Y, VALID, SYNC, CLR_ERR,
    output A, B, C, D, DONE, S1, S0, ERR
  );
endinterface

// File: rtl/demux14_tdm.sv
// Time-division 1-to-4 demultiplexer.
// Slots 0..2 of a frame are parked in shadow registers; the slot-3 beat
// completes the frame, and all four channels are loaded into the output
// registers together with a one-cycle DONE strobe. A SYNC beat always
// restarts the frame at slot 0; if it arrives mid-frame, the partial frame is
// dropped and the sticky ERR flag is raised.
module demux14_tdm #(
  parameter int WIDTH = 1
) (
  input logic          CLK,
  input logic          RST,
  demux14_tdm_if.slave bus
);

  typedef enum logic [1:0] {
    SLOT0 = 2'd0,
    SLOT1 = 2'd1,
    SLOT2 = 2'd2,
    SLOT3 = 2'd3
  } slot_t;

  slot_t            slot_reg;
  slot_t            slot_next;
  logic [WIDTH-1:0] sh_reg [0:2];
  logic [2:0]       sh_load;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] c_reg;
  logic [WIDTH-1:0] d_reg;
  logic             done_reg;
  logic             err_reg;
  logic             err_next;
  logic             frame_done;
  logic             align_err;

  // Slot state register: the slot that the next accepted beat will fill.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      slot_reg <= SLOT0;
    end else begin
      slot_reg <= slot_next;
    end
  end

  // Next slot, frame completion, and alignment error detection.
  always_comb begin
    slot_next  = slot_reg;
    frame_done = 1'b0;
    align_err  = 1'b0;
    if (bus.VALID) begin
      if (bus.SYNC) begin
        // A SYNC beat is slot 0, so the next beat goes to slot 1.
        slot_next = SLOT1;
        align_err = (slot_reg != SLOT0);
      end else begin
        slot_next  = slot_t'(slot_reg + 2'd1);
        frame_done = (slot_reg == SLOT3);
      end
    end
    // A new error takes priority over a clear request on the same edge.
    err_next = align_err | (err_reg & ~bus.CLR_ERR);
  end

  // Per-shadow load enables: a SYNC beat always lands in shadow 0.
  // Otherwise, the current slot selects the shadow register to load.
  // A slot-3 beat loads no shadow register because it goes straight to D.
  for (genvar gi = 0; gi < 3; gi++) begin : g_sh_load
    assign sh_load[gi] = bus.VALID &
                         (bus.SYNC ? (gi == 0) : (slot_reg == 2'(gi)));
  end

  // Shadow registers hold slots 0..2 of the frame that is being assembled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 3; i++) begin
        sh_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sh_load[i]) begin
          sh_reg[i] <= bus.Y;
        end
      end
    end
  end

  // Output frame registers, the DONE strobe, and the sticky error flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_reg    <= '0;
      b_reg    <= '0;
      c_reg    <= '0;
      d_reg    <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      done_reg <= frame_done;
      err_reg  <= err_next;
      if (frame_done) begin
        a_reg <= sh_reg[0];
        b_reg <= sh_reg[1];
        c_reg <= sh_reg[2];
        d_reg <= bus.Y;
      end
    end
  end

  assign bus.A    = a_reg;
  assign bus.B    = b_reg;
  assign bus.C    = c_reg;
  assign bus.D    = d_reg;
  assign bus.DONE = done_reg;
  assign bus.ERR  = err_reg;
  assign bus.S1   = slot_reg[1];
  assign bus.S0   = slot_reg[0];

endmodule

// File: tb/tb_demux14_tdm.sv
// Bench for the 1-to-4 TDM demultiplexer (WIDTH=4).
// A queue-based frame model predicts every output and is compared on each
// falling edge. Directed scenarios add literal checks that pin the model.
module tb_demux14_tdm;
  localparam int W = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  demux14_tdm_if #(.WIDTH(W)) bus ();

  demux14_tdm #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  int frames = 0;

  // Reference model: beats of the current partial frame are kept in a queue.
  // The next slot is the queue length.
  logic [W-1:0] frame_q[$];
  logic [W-1:0] m_a, m_b, m_c, m_d;
  logic         m_done, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising clock edge, plus an asynchronous reset clear.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_q.delete();
      m_a = '0; m_b = '0; m_c = '0; m_d = '0;
      m_done = 1'b0;
      m_err  = 1'b0;
    end else begin
      bit set_err;
      set_err = 1'b0;
      m_done  = 1'b0;
      if (bus.VALID) begin
        if (bus.SYNC) begin
          if (frame_q.size() != 0) set_err = 1'b1;
          frame_q.delete();
          frame_q.push_back(bus.Y);
        end else begin
          frame_q.push_back(bus.Y);
          if (frame_q.size() == 4) begin
            m_a = frame_q[0]; m_b = frame_q[1]; m_c = frame_q[2]; m_d = frame_q[3];
            m_done = 1'b1;
            frame_q.delete();
            frames++;
            $display("frame %0d: A=%h B=%h C=%h D=%h", frames, m_a, m_b, m_c, m_d);
          end
        end
      end
      if (set_err) m_err = 1'b1;
      else if (bus.CLR_ERR) m_err = 1'b0;
    end
  end

  // Compare process: check every DUT output against the model on each falling edge.
  always @(negedge CLK) begin
    if (check_en && !RST) begin
      chk("A", 32'(bus.A), 32'(m_a));
      chk("B", 32'(bus.B), 32'(m_b));
      chk("C", 32'(bus.C), 32'(m_c));
      chk("D", 32'(bus.D), 32'(m_d));
      chk("DONE", 32'(bus.DONE), 32'(m_done));
      chk("ERR", 32'(bus.ERR), 32'(m_err));
      chk("SEL", 32'({bus.S1, bus.S0}), 32'(frame_q.size()));
    end
  end

  // Apply one cycle of inputs: set them at the falling edge, then return 1 time unit after the next rising edge.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] y, input logic c);
    @(negedge CLK);
    bus.VALID   = v;
    bus.SYNC    = s;
    bus.Y       = y;
    bus.CLR_ERR = c;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    bus.VALID = 1'b0; bus.SYNC = 1'b0; bus.Y = '0; bus.CLR_ERR = 1'b0;
    repeat (2) @(posedge CLK);
    #2 RST = 1'b0;
    check_en = 1'b1;
    chk("reset_sel", 32'({bus.S1, bus.S0}), 32'd0);
    chk("reset_done", 32'(bus.DONE), 32'd0);

    // Basic frame: the slot sequence is 1,2,3,0, and DONE is high for exactly one cycle.
    drive(1, 1, 4'd1, 0); chk("basic_sel1", 32'({bus.S1, bus.S0}), 32'd1);
    drive(1, 0, 4'd2, 0); chk("basic_sel2", 32'({bus.S1, bus.S0}), 32'd2);
    drive(1, 0, 4'd3, 0); chk("basic_sel3", 32'({bus.S1, bus.S0}), 32'd3);
    chk("basic_nodone", 32'(bus.DONE), 32'd0);
    drive(1, 0, 4'd4, 0); chk("basic_sel0", 32'({bus.S1, bus.S0}), 32'd0);
    chk("basic_frame", 32'({bus.A, bus.B, bus.C, bus.D}), 32'h1234);
    chk("basic_done", 32'(bus.DONE), 32'd1);
    idle(1);
    chk("basic_done_drop", 32'(bus.DONE), 32'd0);

    // Stalls: the slot holds during gaps, and DONE appears only after the 4th beat.
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0), 4'(i + 5), 0);
      done_cnt += int'(bus.DONE);
      for (int g = 0; g < 2; g++) begin
        idle(1);
        chk("stall_sel_hold", 32'({bus.S1, bus.S0}), 32'((i + 1) % 4));
      end
    end
    chk("stall_done_count", 32'(done_cnt), 32'd1);
    chk("stall_frame", 32'({bus.A, bus.B, bus.C, bus.D}), 32'h5678);

    // Mid-cycle asynchronous reset with a partial frame outstanding.
    drive(1, 1, 4'd9, 0);
    drive(1, 0, 4'd10, 0);
    idle(1);
    chk("pre_reset_A", 32'(bus.A), 32'd5);
    #1 RST = 1'b1;
    #1;
    chk("async_reset_out", 32'({bus.A, bus.B, bus.C, bus.D}), 32'h0);
    chk("async_reset_sel", 32'({bus.S1, bus.S0, bus.DONE, bus.ERR}), 32'h0);
    #1 RST = 1'b0;
    drive(1, 0, 4'd3, 0);
    chk("post_reset_sel", 32'({bus.S1, bus.S0}), 32'd1);
    drive(1, 0, 4'd3, 0); drive(1, 0, 4'd3, 0); drive(1, 0, 4'd3, 0);
    chk("post_reset_frame", 32'({bus.A, bus.B, bus.C, bus.D}), 32'h3333);

    // Back-to-back frames: beats 0xA..0xF, 0x0, 0x1, with SYNC on the first beat only.
    for (int i = 0; i < 8; i++) begin
      drive(1, (i == 0), 4'(10 + i), 0);
      chk("b2b_done", 32'(bus.DONE), 32'((i == 3) || (i == 7)));
    end
    chk("b2b_frame2", 32'({bus.A, bus.B, bus.C, bus.D}), 32'hEF01);

    // Misalignment: SYNC arrives while the slot is 2.
    drive(1, 1, 4'd1, 0); drive(1, 0, 4'd2, 0);
    chk("mis_sel2", 32'({bus.S1, bus.S0}), 32'd2);
    drive(1, 1, 4'd7, 0);
    chk("mis_err", 32'(bus.ERR), 32'd1);
    chk("mis_nodone", 32'(bus.DONE), 32'd0);
    chk("mis_hold", 32'({bus.A, bus.B, bus.C, bus.D}), 32'hEF01);
    drive(1, 0, 4'd8, 0); drive(1, 0, 4'd9, 0); drive(1, 0, 4'd10, 0);
    chk("mis_frame", 32'({bus.A, bus.B, bus.C, bus.D}), 32'h789A);
    chk("mis_done", 32'(bus.DONE), 32'd1);
    chk("mis_err_sticky", 32'(bus.ERR), 32'd1);

    // Error clear priority: a set on the same edge as CLR_ERR wins, and a clear alone then works.
    drive(1, 1, 4'd3, 0);
    drive(1, 1, 4'd4, 1);
    chk("clr_prio_err", 32'(bus.ERR), 32'd1);
    drive(0, 0, 4'd0, 1);
    chk("clr_err", 32'(bus.ERR), 32'd0);
    drive(0, 0, 4'd0, 0);

    // Randomized stream: gaps, occasional SYNC, and random clears.
    for (int i = 0; i < 600; i++) begin
      logic v, s, c;
      v = ($urandom_range(0, 9) < 7);
      s = v && ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 19) == 0);
      drive(v, s, 4'($urandom), c);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
